// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if: req/gnt data-memory bus between the store buffer (master) and backing memory (slave).
interface dmem_store_buffer_if #(parameter int AW = 32);
   logic          mem_req;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;
   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );
   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: CPU store FIFO drained over req/gnt, loads held until conflicting stores drain.
// STORE_MERGE_EN coalesces a same-word store into the newest FIFO entry.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    cpu_write_en,
   input  logic          cpu_read_en,
   input  logic [AW-1:0] cpu_addr,
   input  logic [31:0]   cpu_write_data,
   output logic [31:0]   cpu_read_data,
   output logic          cpu_stall,
   dmem_store_buffer_if.master mem,
   output logic          buf_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] RD_REQ  = 3'd2;
   localparam logic [2:0] RD_WAIT = 3'd3;
   localparam logic [2:0] RD_DONE = 3'd4;

   logic [AW-3:0]    addr_q [DEPTH];
   logic [3:0]       be_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [PW-1:0]    head, tail, last;
   logic [PW:0]      count;
   logic [2:0]       state;
   logic [AW-3:0]    word;
   logic [DEPTH-1:0] hit_v;
   logic [3:0]       merge_be;
   logic [31:0]      merge_data;
   logic             store, rd, full, hit, merge, fwd, enq, deq;
   logic             unused;

   assign word      = cpu_addr[AW-1:2];
   assign unused    = ^cpu_addr[1:0];
   assign store     = |cpu_write_en;
   assign rd        = cpu_read_en & ~store;
   assign full      = count == (PW+1)'(DEPTH);
   assign last      = tail - PW'(1);
   assign hit       = |hit_v;
   assign merge_be  = be_q[last] | cpu_write_en;
`ifdef STORE_MERGE_EN
   assign merge     = store && count != '0 && addr_q[last] == word && !(state == WR_REQ && count == (PW+1)'(1));
`else
   assign merge     = 1'b0;
`endif
   // a merge into the sole entry while IDLE launches it must reach the bus too
   assign fwd       = merge && count == (PW+1)'(1);
   assign enq       = store & ~full & ~merge;
   assign deq       = state == WR_REQ && mem.mem_gnt;
   assign cpu_stall = (store & full & ~merge) | (rd & state != RD_DONE);
   assign buf_empty = count == '0;

   always_comb begin
      hit_v      = '0;
      merge_data = data_q[last];
      for (int i = 0; i < DEPTH; i++)
         hit_v[i] = ({1'b0, PW'(i) - head} < count) && addr_q[i] == word;
      for (int b = 0; b < 4; b++)
         merge_data[8*b +: 8] = cpu_write_en[b] ? cpu_write_data[8*b +: 8] : data_q[last][8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail] <= word;
         be_q[tail]   <= cpu_write_en;
         data_q[tail] <= cpu_write_data;
      end
      if (merge) begin
         be_q[last]   <= merge_be;
         data_q[last] <= merge_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         state         <= IDLE;
         cpu_read_data <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_be    <= '0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
      end else begin
         if (enq) tail <= tail + PW'(1);
         if (deq) head <= head + PW'(1);
         count <= count + (PW+1)'(enq) - (PW+1)'(deq);
         case (state)
            IDLE: begin
               if (rd && !hit) begin
                  state        <= RD_REQ;
                  mem.mem_req  <= 1'b1;
                  mem.mem_we   <= 1'b0;
                  mem.mem_be   <= '0;
                  mem.mem_addr <= {word, 2'b00};
               end else if (count != '0) begin
                  state         <= WR_REQ;
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= 1'b1;
                  mem.mem_be    <= fwd ? merge_be : be_q[head];
                  mem.mem_addr  <= {addr_q[head], 2'b00};
                  mem.mem_wdata <= fwd ? merge_data : data_q[head];
               end
            end
            WR_REQ: begin
               if (mem.mem_gnt) begin
                  mem.mem_req <= 1'b0;
                  state       <= IDLE;
               end
            end
            RD_REQ: begin
               if (mem.mem_gnt) begin
                  mem.mem_req <= 1'b0;
                  state       <= mem.mem_rvalid ? RD_DONE : RD_WAIT;
                  if (mem.mem_rvalid) cpu_read_data <= mem.mem_rdata;
               end
            end
            RD_WAIT: begin
               if (mem.mem_rvalid) begin
                  cpu_read_data <= mem.mem_rdata;
                  state         <= RD_DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
